// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, lane mask helper and responder state type
package sram_pkg;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  typedef enum logic {CLEAR, READY} state_e;
  function automatic logic [SRAM_DATA_W-1:0] lane_mask(input logic hb, input logic lb);
    return {{8{hb}}, {8{lb}}};
  endfunction
endpackage

// File: rtl/sram_read_pipe.sv
// sram_read_pipe: delays read valid/lane mask to line up with registered RAM data
module sram_read_pipe
  import sram_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [SRAM_DATA_W-1:0] mask_i,
  input  logic [SRAM_DATA_W-1:0] data_i,
  output logic                   done_o,
  output logic                   valid_o,
  output logic [SRAM_DATA_W-1:0] data_o
);
  logic [LAT-1:0]         vld_q;
  logic [SRAM_DATA_W-1:0] msk_q [LAT];
  logic [SRAM_DATA_W-1:0] dat;
  always_ff @(posedge clk) begin
    if (reset) vld_q <= '0;
    else begin
      vld_q[0] <= valid_i;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    msk_q[0] <= mask_i;
    for (int i = 1; i < LAT; i++) msk_q[i] <= msk_q[i-1];
  end
  // data_i is already one register deep, so it needs one stage fewer than valid
  if (LAT == 1) begin : g_l1
    assign dat    = data_i;
    assign done_o = valid_i;
  end else begin : g_ln
    logic [SRAM_DATA_W-1:0] dat_q [LAT-1];
    always_ff @(posedge clk) begin
      dat_q[0] <= data_i;
      for (int i = 1; i < LAT - 1; i++) dat_q[i] <= dat_q[i-1];
    end
    assign dat    = dat_q[LAT-2];
    assign done_o = vld_q[LAT-2];
  end
  assign valid_o = vld_q[LAT-1];
  assign data_o  = valid_o ? dat & msk_q[LAT-1] : '0;
endmodule

// File: rtl/sram_responder.sv
// sram_responder: block-RAM SRAM responder with clear-on-reset, protocol checks and access counters
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int READ_LATENCY   = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SRAM_ADDR_W-1:0] ram_addr,
  input  logic [SRAM_DATA_W-1:0] ram_dout,
  input  logic                   ram_ce,
  input  logic                   ram_oe,
  input  logic                   ram_we,
  input  logic                   ram_lb,
  input  logic                   ram_hb,
  output logic [SRAM_DATA_W-1:0] ram_din,
  output logic                   rd_valid,
  output logic                   ready,
  output logic                   err_conflict,
  output logic                   err_busy,
  output logic [15:0]            rd_count,
  output logic [15:0]            wr_count
);
  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      ptr_q, ptr_d;
  logic                   err_conflict_q, err_busy_q;
  logic [15:0]            rd_count_q, wr_count_q;
  logic [SRAM_DATA_W-1:0] mem [2**ADDR_W];
  logic [SRAM_DATA_W-1:0] mem_q;
  logic                   clear, acc_wr, acc_rd, rd_done, unused_addr;
  logic [ADDR_W-1:0]      wa;
  logic [1:0]             be;
  assign unused_addr = ^ram_addr;
  assign ready  = state_q == READY;
  assign clear  = state_q == CLEAR;
  assign acc_wr = ready & ram_ce & ram_we;
  assign acc_rd = ready & ram_ce & ram_oe & ~ram_we;
  always_comb begin
    state_d = clear && &ptr_q ? READY : state_q;
    ptr_d   = clear ? ptr_q + 1'b1 : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CLEAR_ON_RESET ? CLEAR : READY;
      ptr_q          <= '0;
      err_conflict_q <= 1'b0;
      err_busy_q     <= 1'b0;
      rd_count_q     <= '0;
      wr_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      err_conflict_q <= err_conflict_q | (ready & ram_ce & ram_oe & ram_we);
      err_busy_q     <= err_busy_q | (~ready & ram_ce);
      rd_count_q     <= rd_count_q + {15'd0, rd_done};
      wr_count_q     <= wr_count_q + {15'd0, acc_wr};
    end
  end
  // CLEAR borrows the single write port; reads are read-first so a same-address
  // write on a later cycle never disturbs an already-issued read
  assign wa = clear ? ptr_q : ram_addr[ADDR_W-1:0];
  assign be = clear ? 2'b11 : {ram_hb, ram_lb};
  always_ff @(posedge clk) begin
    if (clear | acc_wr) begin
      if (be[0]) mem[wa][7:0]  <= clear ? 8'h00 : ram_dout[7:0];
      if (be[1]) mem[wa][15:8] <= clear ? 8'h00 : ram_dout[15:8];
    end
    mem_q <= mem[wa];
  end
  sram_read_pipe #(.LAT(READ_LATENCY)) u_pipe (
    .clk    (clk),
    .reset  (reset),
    .valid_i(acc_rd),
    .mask_i (lane_mask(ram_hb, ram_lb)),
    .data_i (mem_q),
    .done_o (rd_done),
    .valid_o(rd_valid),
    .data_o (ram_din)
  );
  assign err_conflict = err_conflict_q;
  assign err_busy     = err_busy_q;
  assign rd_count     = rd_count_q;
  assign wr_count     = wr_count_q;
endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: two responders (latency 1 and 3, 16 words) driven in lockstep against a cycle-indexed memory model
module tb_sram_responder;
  logic clk = 1'b0;
  logic reset, ce, oe, we, lb, hb;
  logic [17:0] adr;
  logic [15:0] dout;
  logic [1:0][15:0] din, rc, wc;
  logic [1:0] vld, rdy, ec, eb;
  always #5 clk = ~clk;
  sram_responder #(.ADDR_W(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ram_addr(adr), .ram_dout(dout), .ram_ce(ce), .ram_oe(oe),
    .ram_we(we), .ram_lb(lb), .ram_hb(hb), .ram_din(din[0]), .rd_valid(vld[0]), .ready(rdy[0]),
    .err_conflict(ec[0]), .err_busy(eb[0]), .rd_count(rc[0]), .wr_count(wc[0]));
  sram_responder #(.ADDR_W(4), .READ_LATENCY(3), .CLEAR_ON_RESET(1'b1)) dut3 (
    .clk(clk), .reset(reset), .ram_addr(adr), .ram_dout(dout), .ram_ce(ce), .ram_oe(oe),
    .ram_we(we), .ram_lb(lb), .ram_hb(hb), .ram_din(din[1]), .rd_valid(vld[1]), .ready(rdy[1]),
    .err_conflict(ec[1]), .err_busy(eb[1]), .rd_count(rc[1]), .wr_count(wc[1]));
  int pass_cnt = 0, fail_cnt = 0, total = 0;
  int cyc = 0, clear_left = 0, m_wr = 0;
  int m_rd [2];
  bit m_conf = 0, m_busy = 0;
  logic [15:0] m_mem [16];
  logic [16:0] sched [2][8];
  function automatic int lat(input int d);
    return d == 0 ? 1 : 3;
  endfunction
  task automatic chk(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s (latency %0d) cycle %0d: got %0h, expected %0h", tag, lat(d), cyc, got, exp);
    end
  endtask
  task automatic step(input bit r, input bit c, input bit o, input bit w, input bit l, input bit h,
                      input logic [17:0] a_in, input logic [15:0] d_in);
    int a;
    logic [15:0] msk;
    logic [16:0] exp;
    reset = r; ce = c; oe = o; we = w; lb = l; hb = h; adr = a_in; dout = d_in;
    @(posedge clk);
    cyc++;
    a = int'(a_in) % 16;
    msk = (h ? 16'hFF00 : 16'h0000) | (l ? 16'h00FF : 16'h0000);
    if (r) begin
      clear_left = 16; m_conf = 0; m_busy = 0; m_wr = 0; m_rd[0] = 0; m_rd[1] = 0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) sched[d][i] = '0;
    end else if (clear_left > 0) begin
      if (c) m_busy = 1;
      clear_left--;
      if (clear_left == 0) for (int i = 0; i < 16; i++) m_mem[i] = 16'h0000;
    end else if (c && w) begin
      if (o) m_conf = 1;
      m_mem[a] = (m_mem[a] & ~msk) | (d_in & msk);
      m_wr = (m_wr + 1) % 65536;
    end else if (c && o) begin
      for (int d = 0; d < 2; d++) sched[d][(cyc + lat(d) - 1) % 8] = {1'b1, m_mem[a] & msk};
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      exp = sched[d][cyc % 8];
      sched[d][cyc % 8] = '0;
      if (exp[16]) m_rd[d] = (m_rd[d] + 1) % 65536;
      chk("rd_valid", d, 32'(vld[d]), 32'(exp[16]));
      chk("ram_din", d, 32'(din[d]), 32'(exp[15:0]));
      chk("ready", d, 32'(rdy[d]), 32'(clear_left == 0));
      chk("rd_count", d, 32'(rc[d]), 32'(m_rd[d]));
      chk("wr_count", d, 32'(wc[d]), 32'(m_wr));
      chk("err_conflict", d, 32'(ec[d]), 32'(m_conf));
      chk("err_busy", d, 32'(eb[d]), 32'(m_busy));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 18'h0, 16'h0);
  endtask
  task automatic wr(input logic [17:0] a, input logic [15:0] d, input bit l, input bit h);
    step(0, 1, 0, 1, l, h, a, d);
  endtask
  task automatic rd(input logic [17:0] a, input bit l, input bit h);
    step(0, 1, 1, 0, l, h, a, 16'h0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 18'h0, 16'h0);
    step(1, 1, 1, 1, 1, 1, 18'h5, 16'h5);
    idle(16);
    for (int i = 0; i < 16; i++) rd(18'(i), 1, 1);
    idle(3);
    wr(18'h5, 16'h1234, 1, 1);
    rd(18'h5, 1, 1);
    wr(18'h5, 16'hABCD, 0, 1);
    rd(18'h5, 1, 1);
    rd(18'h5, 1, 0);
    idle(3);
    rd(18'h1, 1, 1); rd(18'h2, 1, 1); rd(18'h3, 1, 1);
    idle(4);
    step(0, 1, 1, 1, 1, 1, 18'h7, 16'h00FF);
    rd(18'h7, 1, 1);
    idle(3);
    wr(18'h00013, 16'hBEEF, 1, 1);
    rd(18'h00003, 1, 1);
    rd(18'h5, 1, 1);
    wr(18'h5, 16'h7777, 1, 1);
    step(0, 1, 1, 0, 0, 0, 18'h5, 16'h0);
    step(0, 0, 1, 1, 1, 1, 18'h9, 16'h9999);
    rd(18'h9, 1, 1);
    idle(3);
    for (int i = 0; i < 400; i++)
      step(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 18'($urandom_range(0, 262143)),
           16'($urandom));
    idle(3);
    step(1, 0, 0, 0, 0, 0, 18'h0, 16'h0);
    idle(9);
    wr(18'h2, 16'hDEAD, 1, 1);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 18'h0, 16'h0);
    idle(4);
    wr(18'h2, 16'hFACE, 1, 1);
    idle(11);
    rd(18'h2, 1, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 18'h0, 16'h0);
    idle(16);
    for (int i = 0; i < 65536; i++) rd(18'(i), 1, 1);
    idle(3);
    chk("rd_count_wrap", 0, 32'(rc[0]), 32'h0);
    chk("rd_count_wrap", 1, 32'(rc[1]), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
